// File: rtl/cam_seq_pkg.sv
// ---------------------------------------------------------------------------
// cam_seq_pkg
// Shared types and constants for the OV7670 power-up register sequencer.
//   state_t      : sequencer FSM states
//   reg_entry_t  : one register-table entry {addr, data}
//   END_MARKER   : table address that terminates the sequence
//   DELAY_MARKER : table address whose data byte is a delay in delay units
// ---------------------------------------------------------------------------
package cam_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_SETTLE,
    ST_FETCH,
    ST_DECODE,
    ST_WAIT_RESP,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } reg_entry_t;

  localparam logic [7:0] END_MARKER   = 8'hFF;
  localparam logic [7:0] DELAY_MARKER = 8'hF0;

  function automatic reg_entry_t mk_entry(input logic [7:0] a, input logic [7:0] d);
    reg_entry_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

endpackage

// File: rtl/cam_reg_rom.sv
// ---------------------------------------------------------------------------
// cam_reg_rom
// Register table for the camera sequencer, read synchronously (one cycle
// from addr_i to entry_o).
//   clk_i   in  1      system clock
//   addr_i  in  IDX_W  table index
//   entry_o out 16     {addr, data} of the entry at the previous cycle's index
// TEST_ROM=0 selects the OV7670 RGB444/VGA bring-up table; TEST_ROM=1 selects
// a short 4-entry table used for simulation. Unlisted indices read as the end
// marker, so running off the end of a table always stops the sequencer.
// ---------------------------------------------------------------------------
module cam_reg_rom
  import cam_seq_pkg::*;
#(
  parameter int ROM_DEPTH = 128,
  parameter bit TEST_ROM  = 1'b0
) (
  input  logic                         clk_i,
  input  logic [$clog2(ROM_DEPTH)-1:0] addr_i,
  output reg_entry_t                   entry_o
);

  reg_entry_t r_entry;

  function automatic reg_entry_t test_table(input int idx);
    case (idx)
      0:       return mk_entry(8'h12, 8'h80);
      1:       return mk_entry(8'hF0, 8'h02);
      2:       return mk_entry(8'h11, 8'h01);
      default: return mk_entry(8'hFF, 8'hFF);
    endcase
  endfunction

  // Soft reset, 10 ms wait, then RGB444 output at VGA with a sane colour
  // matrix, gamma curve and automatic exposure/gain/white balance.
  function automatic reg_entry_t ov7670_table(input int idx);
    case (idx)
      0:       return mk_entry(8'h12, 8'h80);
      1:       return mk_entry(8'hF0, 8'h0A);
      2:       return mk_entry(8'h12, 8'h04);
      3:       return mk_entry(8'h11, 8'h01);
      4:       return mk_entry(8'h0C, 8'h00);
      5:       return mk_entry(8'h3E, 8'h00);
      6:       return mk_entry(8'h04, 8'h00);
      7:       return mk_entry(8'h8C, 8'h02);
      8:       return mk_entry(8'h40, 8'hD0);
      9:       return mk_entry(8'h3A, 8'h04);
      10:      return mk_entry(8'h14, 8'h18);
      11:      return mk_entry(8'h4F, 8'hB3);
      12:      return mk_entry(8'h50, 8'hB3);
      13:      return mk_entry(8'h51, 8'h00);
      14:      return mk_entry(8'h52, 8'h3D);
      15:      return mk_entry(8'h53, 8'hA7);
      16:      return mk_entry(8'h54, 8'hE4);
      17:      return mk_entry(8'h58, 8'h9E);
      18:      return mk_entry(8'h3D, 8'hC0);
      19:      return mk_entry(8'h17, 8'h14);
      20:      return mk_entry(8'h18, 8'h02);
      21:      return mk_entry(8'h32, 8'h80);
      22:      return mk_entry(8'h19, 8'h03);
      23:      return mk_entry(8'h1A, 8'h7B);
      24:      return mk_entry(8'h03, 8'h0A);
      25:      return mk_entry(8'h0F, 8'h41);
      26:      return mk_entry(8'h1E, 8'h00);
      27:      return mk_entry(8'h33, 8'h0B);
      28:      return mk_entry(8'h3C, 8'h78);
      29:      return mk_entry(8'h69, 8'h00);
      30:      return mk_entry(8'h74, 8'h00);
      31:      return mk_entry(8'hB0, 8'h84);
      32:      return mk_entry(8'hB1, 8'h0C);
      33:      return mk_entry(8'hB2, 8'h0E);
      34:      return mk_entry(8'hB3, 8'h80);
      35:      return mk_entry(8'h70, 8'h3A);
      36:      return mk_entry(8'h71, 8'h35);
      37:      return mk_entry(8'h72, 8'h11);
      38:      return mk_entry(8'h73, 8'hF0);
      39:      return mk_entry(8'hA2, 8'h02);
      40:      return mk_entry(8'h13, 8'hE7);
      41:      return mk_entry(8'h6F, 8'h9F);
      default: return mk_entry(8'hFF, 8'hFF);
    endcase
  endfunction

  // Registered read: the sequencer spends one FETCH cycle waiting for this.
  always_ff @(posedge clk_i) begin
    if (TEST_ROM) begin
      r_entry <= test_table(int'(addr_i));
    end else begin
      r_entry <= ov7670_table(int'(addr_i));
    end
  end

  assign entry_o = r_entry;

endmodule

// File: rtl/cam_reg_sequencer.sv
// ---------------------------------------------------------------------------
// cam_reg_sequencer
// Power-up configuration sequencer for the OV7670: holds the camera in reset,
// waits for the sensor to settle, then walks the register table issuing one
// SCCB write per entry through a req/ack handshake, honouring delay entries.
//   clk_i        in  1   system clock
//   reset_i      in  1   asynchronous active-low reset
//   start_i      in  1   pulse; restarts the sequence from DONE/ERROR
//   wr_req_o     out 1   write request to the SCCB master
//   wr_addr_o    out 8   register address, valid while wr_req_o=1
//   wr_data_o    out 8   register data, valid while wr_req_o=1
//   wr_ack_i     in  1   pulse: write ACKed
//   wr_nack_i    in  1   pulse: write NACKed (wins over a same-cycle ack)
//   reset_cmos_o out 1   camera reset pin, active-low
//   busy_o       out 1   sequence in progress
//   done_o       out 1   table completed; sticky until restart
//   error_o      out 1   write failed; sticky until restart
//   index_o      out IDX current table index
// Build option CAM_SEQ_RETRY_EN: a NACKed write is re-issued up to
// MAX_RETRIES times before giving up; without it the first NACK is fatal.
// TEST_ROM selects the short simulation table in cam_reg_rom.
// ---------------------------------------------------------------------------
module cam_reg_sequencer
  import cam_seq_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 100_000,
  parameter int SETTLE_CYCLES     = 1_000_000,
  parameter int DELAY_UNIT_CYCLES = 100_000,
  parameter int ROM_DEPTH         = 128,
`ifdef CAM_SEQ_RETRY_EN
  parameter int MAX_RETRIES       = 3,
`endif
  parameter bit TEST_ROM          = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  output logic                         wr_req_o,
  output logic [7:0]                   wr_addr_o,
  output logic [7:0]                   wr_data_o,
  input  logic                         wr_ack_i,
  input  logic                         wr_nack_i,
  output logic                         reset_cmos_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic [$clog2(ROM_DEPTH)-1:0] index_o
);

  localparam int IDX_W     = $clog2(ROM_DEPTH);
  localparam int MAX_DELAY = 255 * DELAY_UNIT_CYCLES;
  localparam int MAX_A     = (RESET_HOLD_CYCLES > SETTLE_CYCLES) ? RESET_HOLD_CYCLES : SETTLE_CYCLES;
  localparam int MAX_LOAD  = (MAX_A > MAX_DELAY) ? MAX_A : MAX_DELAY;
  localparam int CNT_W     = $clog2(MAX_LOAD + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);

  state_t            r_state, w_state_n;
  logic [CNT_W-1:0]  r_count, w_count_n;
  logic [IDX_W-1:0]  r_index, w_index_n;
  logic [7:0]        r_addr, w_addr_n;
  logic [7:0]        r_data, w_data_n;
  logic              w_advance;
  reg_entry_t        w_entry;

`ifdef CAM_SEQ_RETRY_EN
  localparam int RTRY_W = $clog2(MAX_RETRIES + 1);
  logic [RTRY_W-1:0] r_retry, w_retry_n;
`endif

  cam_reg_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .TEST_ROM  (TEST_ROM)
  ) u_rom (
    .clk_i   (clk_i),
    .addr_i  (r_index),
    .entry_o (w_entry)
  );

  // State and datapath registers. The one down-counter is reused for the
  // reset hold, the settle time and table delays, since they never overlap.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= ST_RST_HOLD;
      r_count <= CNT_W'(RESET_HOLD_CYCLES - 1);
      r_index <= '0;
      r_addr  <= '0;
      r_data  <= '0;
`ifdef CAM_SEQ_RETRY_EN
      r_retry <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_index <= w_index_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
`ifdef CAM_SEQ_RETRY_EN
      r_retry <= w_retry_n;
`endif
    end
  end

  // Next-state logic. w_advance marks "this entry is finished": step to the
  // next one, or stop at the last table slot rather than wrapping the index.
  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_index_n = r_index;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    w_advance = 1'b0;
`ifdef CAM_SEQ_RETRY_EN
    w_retry_n = r_retry;
`endif

    case (r_state)
      ST_RST_HOLD: begin
        if (r_count == '0) begin
          w_state_n = ST_SETTLE;
          w_count_n = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          w_count_n = r_count - 1'b1;
        end
      end

      ST_SETTLE: begin
        if (r_count == '0) begin
          w_state_n = ST_FETCH;
        end else begin
          w_count_n = r_count - 1'b1;
        end
      end

      ST_FETCH: begin
`ifdef CAM_SEQ_RETRY_EN
        w_retry_n = '0;
`endif
        w_state_n = ST_DECODE;
      end

      ST_DECODE: begin
        if (w_entry.addr == END_MARKER) begin
          w_state_n = ST_DONE;
        end else if (w_entry.addr == DELAY_MARKER) begin
          if (w_entry.data == 8'h00) begin
            w_advance = 1'b1;
          end else begin
            w_count_n = CNT_W'(w_entry.data) * CNT_W'(DELAY_UNIT_CYCLES) - 1'b1;
            w_state_n = ST_DELAY;
          end
        end else begin
          w_addr_n  = w_entry.addr;
          w_data_n  = w_entry.data;
          w_state_n = ST_WAIT_RESP;
        end
      end

      ST_WAIT_RESP: begin
        // A nack is checked first so a simultaneous ack/nack counts as a nack.
        if (wr_nack_i) begin
`ifdef CAM_SEQ_RETRY_EN
          // Going back through DECODE drops the request for one cycle and
          // re-raises it with the same ROM entry, which is still on entry_o.
          if (r_retry < RTRY_W'(MAX_RETRIES)) begin
            w_retry_n = r_retry + 1'b1;
            w_state_n = ST_DECODE;
          end else begin
            w_state_n = ST_ERROR;
          end
`else
          w_state_n = ST_ERROR;
`endif
        end else if (wr_ack_i) begin
          w_advance = 1'b1;
        end
      end

      ST_DELAY: begin
        if (r_count == '0) begin
          w_advance = 1'b1;
        end else begin
          w_count_n = r_count - 1'b1;
        end
      end

      ST_DONE, ST_ERROR: begin
        if (start_i) begin
          w_index_n = '0;
          w_count_n = CNT_W'(RESET_HOLD_CYCLES - 1);
          w_state_n = ST_RST_HOLD;
        end
      end

      default: begin
        w_state_n = ST_RST_HOLD;
        w_count_n = CNT_W'(RESET_HOLD_CYCLES - 1);
      end
    endcase

    if (w_advance) begin
      if (r_index == LAST_IDX) begin
        w_state_n = ST_DONE;
      end else begin
        w_index_n = r_index + 1'b1;
        w_state_n = ST_FETCH;
      end
    end
  end

  // Outputs decode straight from the state register so an asynchronous reset
  // drops the request and pulls the camera reset low without a clock edge.
  assign reset_cmos_o = (r_state != ST_RST_HOLD);
  assign wr_req_o     = (r_state == ST_WAIT_RESP);
  assign wr_addr_o    = r_addr;
  assign wr_data_o    = r_data;
  assign done_o       = (r_state == ST_DONE);
  assign error_o      = (r_state == ST_ERROR);
  assign busy_o       = !((r_state == ST_DONE) || (r_state == ST_ERROR));
  assign index_o      = r_index;

endmodule
